// File: rtl/periwinkle_alu_pkg.sv
// -----------------------------------------------------------------------------
// periwinkle_alu_pkg
// Shared definitions for the ALU op-cell arbiter.
//   - Default sizing for the arbiter (requester count, data width, timeout).
//   - State encoding of the arbiter FSM and the enum type built on it.
// -----------------------------------------------------------------------------
package periwinkle_alu_pkg;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_TIMEOUT = 15;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SEND_A  = 3'd1;
   localparam logic [2:0] ST_SEND_B  = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_DELIVER = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      SEND_A  = ST_SEND_A,
      SEND_B  = ST_SEND_B,
      WAIT    = ST_WAIT,
      DELIVER = ST_DELIVER
   } arb_state_e;

endpackage

// File: rtl/alu_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_rr_pick
// Combinational round-robin picker: returns the first set bit of i_valid at or
// after i_ptr, wrapping modulo N_REQ.
// Ports:
//   i_valid  in   N_REQ   request vector
//   i_ptr    in   IDX_W   index with highest priority this cycle
//   o_any    out  1       at least one request is set
//   o_idx    out  IDX_W   chosen index (0 when o_any is low)
// -----------------------------------------------------------------------------
module alu_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_any,
   output logic [IDX_W-1:0] o_idx
);

   localparam int SUM_W = IDX_W + 1;

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [SUM_W-1:0]   sum;

   // Rotating a doubled copy puts requester i_ptr at bit 0, so the lowest set
   // bit of rot is the round-robin winner expressed as an offset from i_ptr.
   assign dbl = {i_valid, i_valid} >> i_ptr;
   assign rot = dbl[N_REQ-1:0];

   always_comb begin
      o_any = 1'b0;
      o_idx = '0;
      sum   = '0;
      // Walk offsets from high to low so the smallest offset is written last.
      for (int off = N_REQ - 1; off >= 0; off--) begin
         if (rot[off]) begin
            o_any = 1'b1;
            sum   = {1'b0, i_ptr} + SUM_W'(off);
            if (sum >= SUM_W'(N_REQ)) begin
               sum = sum - SUM_W'(N_REQ);
            end
            o_idx = sum[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/alu_op_arbiter.sv
// -----------------------------------------------------------------------------
// alu_op_arbiter
// Shares a single two-operand ALU op cell between N_REQ requesters. A request
// is granted round-robin, its operands are pushed into the cell as two words
// (A then B), the result is drained and handed back to the granted requester.
// Exactly one transaction is in flight at a time.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req_valid/a/b          per-requester operand pair (slice k = [k*WIDTH +: WIDTH])
//   o_req_ready              one-hot accept pulse (IDLE only)
//   o_rsp_valid/data/error   one-hot response, shared data bus, timeout flag
//   i_rsp_ready              per-requester response accept
//   o_cell_data_valid/data   operand words to the op cell
//   o_cell_result_ready      result drain to the op cell
//   i_cell_result_valid/res  result from the op cell
//   o_busy                   high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module alu_op_arbiter
   import periwinkle_alu_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req_valid,
   input  logic [N_REQ*WIDTH-1:0] i_req_a,
   input  logic [N_REQ*WIDTH-1:0] i_req_b,
   output logic [N_REQ-1:0]       o_req_ready,
   output logic [N_REQ-1:0]       o_rsp_valid,
   output logic [WIDTH-1:0]       o_rsp_data,
   output logic                   o_rsp_error,
   input  logic [N_REQ-1:0]       i_rsp_ready,
   output logic                   o_cell_data_valid,
   output logic [WIDTH-1:0]       o_cell_data,
   output logic                   o_cell_result_ready,
   input  logic                   i_cell_result_valid,
   input  logic [WIDTH-1:0]       i_cell_result,
   output logic                   o_busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_e       state_q;
   logic [IDX_W-1:0] g_q;
   logic [IDX_W-1:0] ptr_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] rsp_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] ptr_d;

   alu_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_valid (i_req_valid),
      .i_ptr   (ptr_q),
      .o_any   (pick_any),
      .o_idx   (pick_idx)
   );

   // Priority moves to the requester just after the one served.
   assign ptr_d = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + IDX_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rsp_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  g_q     <= pick_idx;
                  a_q     <= i_req_a[pick_idx*WIDTH +: WIDTH];
                  b_q     <= i_req_b[pick_idx*WIDTH +: WIDTH];
                  state_q <= SEND_A;
               end
            end
            SEND_A: begin
               state_q <= SEND_B;
            end
            SEND_B: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (i_cell_result_valid) begin
                  rsp_q   <= i_cell_result;
                  err_q   <= 1'b0;
                  state_q <= DELIVER;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  // WAIT has lasted TIMEOUT cycles: give up on the cell.
                  rsp_q   <= '0;
                  err_q   <= 1'b1;
                  state_q <= DELIVER;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DELIVER: begin
               if (i_rsp_ready[g_q]) begin
                  ptr_q   <= ptr_d;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // One-hot decodes: the accept pulse must land in the grant cycle itself to
   // reach the 5-cycle turnaround, so it follows the picker while in IDLE.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
         assign o_req_ready[gi] = (state_q == IDLE) && pick_any && (pick_idx == IDX_W'(gi));
         assign o_rsp_valid[gi] = (state_q == DELIVER) && (g_q == IDX_W'(gi));
      end
   endgenerate

   assign o_rsp_data          = (state_q == DELIVER) ? rsp_q : '0;
   assign o_rsp_error         = (state_q == DELIVER) && err_q;
   assign o_cell_data_valid   = (state_q == SEND_A) || (state_q == SEND_B);
   assign o_cell_data         = (state_q == SEND_A) ? a_q :
                                (state_q == SEND_B) ? b_q : '0;
   // Same-cycle drain: accept the cell result the moment it is offered.
   assign o_cell_result_ready = (state_q == WAIT) && i_cell_result_valid;
   assign o_busy              = (state_q != IDLE);

endmodule
